// File: rtl/ntt_pkg.sv
// Shared types and constant-evaluation helpers for the sequenced NTT.
// FSM encoding, bit reversal, modular arithmetic and twiddle generation.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CALC  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    r = 0;
    for (int b = 0; b < 32; b++) begin
      if ((64'd1 << b) < 64'(x)) r = 32'(b + 1);
    end
    return r;
  endfunction

  function automatic int unsigned bitrev(input int unsigned x, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int b = 0; b < 32; b++) begin
      if (32'(b) < bits) r = r | (((x >> b) & 32'd1) << (bits - 1 - 32'(b)));
    end
    return r;
  endfunction

  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned q);
    longint unsigned s;
    s = 64'(a) + 64'(b);
    if (s >= 64'(q)) s = s - 64'(q);
    return 32'(s);
  endfunction

  function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                          input int unsigned q);
    longint unsigned s;
    s = 64'(a) + 64'(q) - 64'(b);
    if (s >= 64'(q)) s = s - 64'(q);
    return 32'(s);
  endfunction

  function automatic int unsigned mod_mul(input int unsigned a, input int unsigned b,
                                          input int unsigned q);
    longint unsigned p;
    p = (64'(a) * 64'(b)) % 64'(q);
    return 32'(p);
  endfunction

  // Entry t of the twiddle table, ROOT^t mod Q
  function automatic int unsigned twiddle(input int unsigned root, input int unsigned q,
                                          input int unsigned t);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < t; i++) r = mod_mul(r, root, q);
    return r;
  endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Cooley-Tukey butterfly: (u, v, w) -> (u + v*w, u - v*w) mod Q, purely combinational.
module ntt_butterfly #(
  parameter int N = 9,
  parameter int Q = 257
) (
  input  logic [N-1:0] i_u,
  input  logic [N-1:0] i_v,
  input  logic [N-1:0] i_w,
  output logic [N-1:0] o_x,
  output logic [N-1:0] o_y
);

  localparam logic [2*N-1:0] QP  = (2*N)'(Q);
  localparam logic [N:0]     QN1 = (N+1)'(Q);

  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] w_prod_r;
  logic [N-1:0]   w_vw;
  logic [N:0]     w_sum;
  logic [N:0]     w_sum_r;
  logic [N:0]     w_dif;
  logic [N:0]     w_dif_r;

  assign w_prod   = {{N{1'b0}}, i_v} * {{N{1'b0}}, i_w};
  assign w_prod_r = w_prod % QP;
  assign w_vw     = w_prod_r[N-1:0];

  // Both operands are below Q, so one conditional subtract fully reduces
  assign w_sum   = {1'b0, i_u} + {1'b0, w_vw};
  assign w_sum_r = (w_sum >= QN1) ? (w_sum - QN1) : w_sum;
  assign w_dif   = {1'b0, i_u} + QN1 - {1'b0, w_vw};
  assign w_dif_r = (w_dif >= QN1) ? (w_dif - QN1) : w_dif;

  assign o_x = w_sum_r[N-1:0];
  assign o_y = w_dif_r[N-1:0];

endmodule

// File: rtl/ntt_seq.sv
// Iterative radix-2 NTT sequencer: load in bit-reversed order, one butterfly per cycle, drain.
// Optional input reduction mod Q under NTT_SEQ_IN_REDUCE_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_LOAD  | accept D coefficients, store coefficient c at bitrev(c)
//   ST_CALC  | one butterfly per cycle over log2(D) stages
//   ST_DRAIN | stream A[0..D-1] out under out_ready back-pressure
module ntt_seq
  import ntt_pkg::*;
#(
  parameter int N    = 9,
  parameter int D    = 8,
  parameter int Q    = 257,
  parameter int ROOT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam int LG    = int'(clog2(D));
  localparam int AW    = LG;
  localparam int XW    = LG + 1;
  localparam int TW_AW = (LG > 1) ? LG - 1 : 1;
  localparam logic [AW-1:0] LAST = AW'(D - 1);

  state_t        r_state;
  logic [AW-1:0] r_cnt_in;
  logic [AW-1:0] r_cnt_out;
  logic [AW-1:0] r_stage;
  logic [AW-1:0] r_grp;
  logic [AW-1:0] r_j;
  logic [N-1:0]  r_mem [D];

  logic [N-1:0]  w_tw_tab [D/2];
  logic [XW-1:0] w_half;
  logic [XW-1:0] w_grp_nx;
  logic [AW-1:0] w_i;
  logic [AW-1:0] w_ih;
  logic [AW-1:0] w_tw_sh;
  logic [AW-1:0] w_tw_idx;
  logic          w_j_last;
  logic          w_grp_last;
  logic          w_stage_last;
  logic [31:0]   w_brev_full;
  logic [AW-1:0] w_wr_addr;
  logic [N-1:0]  w_in_val;
  logic [N-1:0]  w_u;
  logic [N-1:0]  w_v;
  logic [N-1:0]  w_w;
  logic [N-1:0]  w_x;
  logic [N-1:0]  w_y;

  for (genvar t = 0; t < D/2; t++) begin : g_tw
    localparam int unsigned TV = twiddle(ROOT, Q, t);
    assign w_tw_tab[t] = TV[N-1:0];
  end

  // Butterfly addressing: i = g + j, partner i + half, twiddle index j * D/(2*half)
  assign w_half       = XW'(1) << r_stage;
  assign w_i          = r_grp + r_j;
  assign w_ih         = w_i + w_half[AW-1:0];
  assign w_tw_sh      = AW'(LG - 1) - r_stage;
  assign w_tw_idx     = r_j << w_tw_sh;
  assign w_grp_nx     = {1'b0, r_grp} + (w_half << 1);
  assign w_j_last     = (r_j == (w_half[AW-1:0] - AW'(1)));
  assign w_grp_last   = (w_grp_nx == XW'(D));
  assign w_stage_last = (r_stage == AW'(LG - 1));

  assign w_brev_full = bitrev(32'(r_cnt_in), LG);
  assign w_wr_addr   = w_brev_full[AW-1:0];

`ifdef NTT_SEQ_IN_REDUCE_EN
  localparam logic [N-1:0] QN = N'(Q);
  assign w_in_val = in_data % QN;
`else
  assign w_in_val = in_data;
`endif

  assign w_u = r_mem[w_i];
  assign w_v = r_mem[w_ih];
  assign w_w = w_tw_tab[w_tw_idx[TW_AW-1:0]];

  ntt_butterfly #(.N(N), .Q(Q)) u_bfly (
    .i_u (w_u),
    .i_v (w_v),
    .i_w (w_w),
    .o_x (w_x),
    .o_y (w_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_cnt_in  <= '0;
      r_cnt_out <= '0;
      r_stage   <= '0;
      r_grp     <= '0;
      r_j       <= '0;
      for (int a = 0; a < D; a++) r_mem[a] <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            r_mem[w_wr_addr] <= w_in_val;
            if (r_cnt_in == LAST) begin
              r_cnt_in <= '0;
              r_state  <= ST_CALC;
            end else begin
              r_cnt_in <= r_cnt_in + AW'(1);
            end
          end
        end
        ST_CALC: begin
          r_mem[w_i]  <= w_x;
          r_mem[w_ih] <= w_y;
          if (w_j_last) begin
            r_j <= '0;
            if (w_grp_last) begin
              r_grp <= '0;
              if (w_stage_last) begin
                r_stage <= '0;
                r_state <= ST_DRAIN;
              end else begin
                r_stage <= r_stage + AW'(1);
              end
            end else begin
              r_grp <= w_grp_nx[AW-1:0];
            end
          end else begin
            r_j <= r_j + AW'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (r_cnt_out == LAST) begin
              r_cnt_out <= '0;
              r_state   <= ST_LOAD;
            end else begin
              r_cnt_out <= r_cnt_out + AW'(1);
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // done marks the final output handshake itself, so in_ready follows one cycle later
  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_DRAIN);
  assign busy      = (r_state == ST_CALC) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DRAIN) && out_ready && (r_cnt_out == LAST);
  assign out_data  = r_mem[r_cnt_out];

endmodule

// File: tb/tb_ntt_seq.sv
// Self-checking bench for ntt_seq: directed frames plus random data and stalls,
// checked against a direct O(D^2) DFT-mod-Q reference.
module tb_ntt_seq;

  localparam int N    = 9;
  localparam int D    = 8;
  localparam int Q    = 257;
  localparam int ROOT = 4;
  localparam int LG   = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic         busy;
  logic         done;

  ntt_seq #(.N(N), .D(D), .Q(Q), .ROOT(ROOT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int a_q   [D];
  int x_exp [D];
  int first_acc;
  int done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint powmod(input longint b, input longint e);
    longint r;
    r = 1;
    for (longint i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  // X[k] = sum_n a[n] * ROOT^(n*k) mod Q
  task automatic model();
    for (int k = 0; k < D; k++) begin
      longint s;
      s = 0;
      for (int n = 0; n < D; n++) s = (s + (longint'(a_q[n]) % Q) * powmod(ROOT, n * k)) % Q;
      x_exp[k] = int'(s);
    end
  endtask

  task automatic fill_const(input int v);
    for (int n = 0; n < D; n++) a_q[n] = v;
  endtask

  task automatic fill_rand();
    for (int n = 0; n < D; n++) a_q[n] = int'($urandom_range(Q - 1));
  endtask

  // Enter at a negedge; hold rst_n low across `cycles` rising edges, then check reset values.
  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    in_valid  = 1'(($urandom_range(1)));
    in_data   = N'($urandom);
    out_ready = 1'b1;
    repeat (cycles) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
  endtask

  // Enter at a negedge; offer a_q[0..n_load-1], leave at the negedge after the last accept.
  task automatic load_frame(input int stall_pct, input int n_load);
    int acc;
    int guard;
    acc = 0;
    guard = 0;
    first_acc = -1;
    while (acc < n_load && guard < 500) begin
      in_valid = (int'($urandom_range(99)) >= stall_pct);
      in_data  = in_valid ? N'(a_q[acc]) : N'($urandom);
      #1;
      if (in_valid && in_ready) begin
        if (acc == 0) first_acc = cyc;
        acc++;
      end
      guard++;
      @(negedge clk);
    end
    if (guard >= 500) check("load_timeout", 32'(acc), 32'(n_load));
    in_valid = 1'b0;
  endtask

  // Runs through CALC (with garbage on in_valid/out_ready); stops early after abort_at cycles.
  task automatic calc_phase(input int abort_at);
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    while (cnt < 100) begin
      in_valid  = 1'(($urandom_range(1)));
      in_data   = N'($urandom);
      out_ready = 1'(($urandom_range(1)));
      #1;
      if (out_valid) break;
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      cnt++;
      if (cnt == abort_at) return;
      @(negedge clk);
    end
    check("calc_cycles", 32'(cnt), 32'((D / 2) * LG));
    check("calc_ctrl_bad_cycles", 32'(bad), 0);
  endtask

  // Called inside the first DRAIN cycle; consumes `limit` outputs.
  task automatic drain_phase(input int stall_pct, input int limit);
    int k;
    int guard;
    logic [N-1:0] prev;
    logic         stalled;
    k = 0;
    guard = 0;
    stalled = 1'b0;
    prev = '0;
    done_cyc = -1;
    while (k < limit && guard < 500) begin
      in_valid  = 1'(($urandom_range(1)));
      out_ready = (int'($urandom_range(99)) >= stall_pct);
      #1;
      check("drain_out_valid", 32'(out_valid), 1);
      check("drain_in_ready", 32'(in_ready), 0);
      check("drain_busy", 32'(busy), 1);
      check($sformatf("drain_X%0d", k), 32'(out_data), 32'(x_exp[k]));
      check("drain_done", 32'(done), 32'(out_ready && (k == D - 1)));
      if (stalled) check("drain_stable", 32'(out_data), 32'(prev));
      if (done) done_cyc = cyc;
      prev    = out_data;
      stalled = !out_ready;
      if (out_ready) k++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 500) check("drain_timeout", 32'(k), 32'(limit));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (limit == D) begin
      #1;
      check("post_in_ready", 32'(in_ready), 1);
      check("post_out_valid", 32'(out_valid), 0);
      check("post_busy", 32'(busy), 0);
      check("post_done", 32'(done), 0);
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input int in_stall, input int out_stall);
    model();
    load_frame(in_stall, D);
    calc_phase(-1);
    drain_phase(out_stall, D);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);

    // All ones, no stalls: done on the 28th cycle counting the first accept as cycle 1
    fill_const(1);
    run_frame(0, 0);
    check("x0_all_ones", 32'(x_exp[0]), 8);
    check("done_cycle", 32'(done_cyc - first_acc), 27);

    fill_const(0); a_q[0] = 1;
    run_frame(0, 0);

    fill_const(0); a_q[1] = 1;
    run_frame(0, 0);
    check("x5_a1_ref", 32'(x_exp[5]), 253);

    fill_const(0); a_q[1] = 1;
    run_frame(40, 40);

    for (int f = 0; f < 4; f++) begin
      fill_rand();
      run_frame(int'($urandom_range(60)), int'($urandom_range(60)));
    end

    // Reset mid-CALC, then a clean all-ones frame
    fill_rand();
    load_frame(0, D);
    calc_phase(5);
    @(negedge clk);
    do_reset(1);
    fill_const(1);
    run_frame(0, 0);

    // Reset mid-LOAD
    fill_rand();
    load_frame(20, 3);
    do_reset(1);
    fill_const(0); a_q[0] = 1;
    run_frame(0, 0);

    // Reset mid-DRAIN
    fill_rand();
    model();
    load_frame(0, D);
    calc_phase(-1);
    drain_phase(30, 3);
    do_reset(1);
    fill_const(0); a_q[1] = 1;
    run_frame(25, 25);

`ifdef NTT_SEQ_IN_REDUCE_EN
    fill_const(258);
    run_frame(0, 0);
    check("reduce_x0", 32'(x_exp[0]), 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc);
    $fatal(1, "global timeout");
  end

endmodule
